mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Decodes the opcode latched in the instruction register and sequences PC, instruction register, register file, ALU and memory enables across the FETCH/DECODE/EXECUTE/MEM/WB steps.
- Selects how the 16-bit immediate reaches the ALU: sign-extended, sign-extended and shifted left by 2, or zero-extended when the optional feature is enabled.
- Handshakes with a shared instruction/data memory that may stall.

---
 rtl/mips_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Main control FSM for a multicycle MIPS datapath. Sequences
//               FETCH / DECODE / EXECUTE / MEM / WB steps from the latched
//               opcode and handshakes with a shared, possibly stalling,
//               instruction/data memory. An optional memory-wait timeout
//               (MAX_WAIT) raises bus_err and returns to FETCH.
// Optional    : define MIPS_CTRL_LOGIC_IMM_EN to decode andi/ori through the
//               LOGEX state with a zero-extended immediate (ext_op = 1).
// Ports       : clk, rst_n (async, active low)
//               op[5:0], zero, mem_ready                 - inputs
//               mem_req, iord, mem_write, ir_write       - memory / IR
//               reg_dst, mem_to_reg, reg_write           - register file
//               alu_src_a, alu_src_b[1:0], alu_op[1:0]   - ALU steering
//               ext_op, pc_src[1:0], pc_en               - immediate / PC
//               illegal_op, bus_err                      - one-cycle pulses
//               state_dbg[3:0]                           - current state
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_IMMEX    = 4'd9;
    localparam logic [3:0] S_IMMWB    = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
    localparam logic [3:0] S_LOGEX    = 4'd12;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    // Terminal count of the wait counter; unused when MAX_WAIT == 0.
    localparam int              C_TMO_INT = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
    localparam logic [WAIT_W-1:0] C_TMO   = WAIT_W'(C_TMO_INT);

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_wait_state;
    logic              w_timeout;
    logic              w_illegal;

    // States that wait on the memory handshake.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                          (r_state == S_MEMWRITE);

    // mem_ready wins over the timeout, so the timeout requires !mem_ready.
    always_comb begin
        w_timeout = 1'b0;
        if ((MAX_WAIT != 0) && w_wait_state && !mem_ready && (r_wait_cnt == C_TMO))
            w_timeout = 1'b1;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter: cleared on any state change and on a timeout (so a
    // timed-out fetch retries from zero), counts stalled cycles otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((w_next != r_state) || w_timeout) begin
            r_wait_cnt <= '0;
        end else if (w_wait_state && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_IMMEX;
                    OP_J:         w_next = S_JUMP;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
                    OP_ANDI, OP_ORI: w_next = S_LOGEX;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready || w_timeout) w_next = S_FETCH;
            end
            S_EXECUTE:  w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_IMMEX:    w_next = S_IMMWB;
            S_IMMWB:    w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
            S_LOGEX:    w_next = S_IMMWB;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Gated by rst_n so an in-flight memory request is
    // withdrawn the instant reset asserts, independent of the clock.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        ext_op     = 1'b0;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    bus_err   = w_timeout;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = w_illegal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    bus_err = w_timeout;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    bus_err   = w_timeout;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                S_IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_IMMWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
`ifdef MIPS_CTRL_LOGIC_IMM_EN
                S_LOGEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_op    = 1'b1;
                    alu_op    = 2'b11;
                end
`endif
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Self-checking bench for mips_multicycle_ctrl (MAX_WAIT = 4).
//               Directed scenarios plus a randomized instruction stream
//               checked against a step-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, ext_op, pc_en, illegal_op, bus_err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_op(ext_op), .pc_src(pc_src), .pc_en(pc_en),
        .illegal_op(illegal_op), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    wire [17:0] obs = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_op, ext_op, pc_src,
                       pc_en, illegal_op, bus_err};

    // Expected control word for a step, straight from the step table.
    function automatic logic [17:0] model_out(int s, logic rdy, logic z,
                                              logic tmo, logic ill);
        logic mreq = 0, io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        logic eo = 0, pe = 0, il = 0, be = 0;
        case (s)
            0:  begin mreq = 1; sb = 2'b01; irw = rdy; pe = rdy; be = tmo; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mreq = 1; io = 1; be = tmo; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; mw = 1; io = 1; be = tmo; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; end
            11: begin ps = 2'b10; pe = 1; end
            12: begin sa = 1; sb = 2'b10; eo = 1; ao = 2'b11; end
            default: ;
        endcase
        return {mreq, io, mw, irw, rd, m2r, rw, sa, sb, ao, eo, ps, pe, il, be};
    endfunction

    // Execution steps after FETCH for a given opcode; empty tail = illegal.
    function automatic int steps_for(logic [5:0] o, int idx);
        int seq[4];
        int n;
        seq = '{0, 0, 0, 0};
        n = 0;
        case (o)
            6'b100011: begin seq = '{1, 2, 3, 4};   n = 4; end
            6'b101011: begin seq = '{1, 2, 5, 0};   n = 3; end
            6'b000000: begin seq = '{1, 6, 7, 0};   n = 3; end
            6'b000100: begin seq = '{1, 8, 0, 0};   n = 2; end
            6'b001000: begin seq = '{1, 9, 10, 0};  n = 3; end
            6'b000010: begin seq = '{1, 11, 0, 0};  n = 2; end
`ifdef MIPS_CTRL_LOGIC_IMM_EN
            6'b001100, 6'b001101: begin seq = '{1, 12, 10, 0}; n = 3; end
`endif
            default:   begin seq = '{1, 0, 0, 0};   n = 1; end
        endcase
        if (idx < 0) return n;
        return seq[idx];
    endfunction

    task automatic set_in(input logic [5:0] o, input logic z, input logic r);
        op = o; zero = z; mem_ready = r;
        #1;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0; op = 6'b100011; zero = 1'b1; mem_ready = 1'b0;
        #2;
        checks++;
        if (obs !== 18'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected %h", obs, 18'd0);
        end
        checks++;
        if (state_dbg !== 4'd0) begin
            failures++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            failures++; $display("FAIL reset_outputs_ready: got %h expected %h", obs, 18'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lw_no_stall;
        int exp_st[5];
        exp_st = '{0, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            set_in(6'b100011, 1'b0, 1'b1);
            checks++;
            if (state_dbg !== 4'(exp_st[i])) begin
                failures++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_dbg, exp_st[i]);
            end
            checks++;
            if ({reg_write, mem_to_reg} !== ((i == 4) ? 2'b11 : 2'b00)) begin
                failures++; $display("FAIL lw_wb_en[%0d]: got %b expected %b", i,
                                     {reg_write, mem_to_reg}, (i == 4) ? 2'b11 : 2'b00);
            end
            checks++;
            if (obs !== model_out(exp_st[i], 1'b1, 1'b0, 1'b0, 1'b0)) begin
                failures++; $display("FAIL lw_ctrl[%0d]: got %h expected %h", i, obs,
                                     model_out(exp_st[i], 1'b1, 1'b0, 1'b0, 1'b0));
            end
            next_cycle();
        end
        checks++;
        if (state_dbg !== 4'd0) begin
            failures++; $display("FAIL lw_latency: got state %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_branch;
        for (int zz = 1; zz >= 0; zz--) begin
            set_in(6'b000100, zz[0], 1'b1);
            next_cycle();
            set_in(6'b000100, zz[0], 1'b0);
            next_cycle();
            set_in(6'b000100, zz[0], 1'b0);
            checks++;
            if ({state_dbg, alu_op, pc_src, pc_en} !== {4'd8, 2'b01, 2'b01, zz[0]}) begin
                failures++; $display("FAIL beq_z%0d: got st=%0d aluop=%b pcsrc=%b pcen=%b expected st=8 01 01 %b",
                                     zz, state_dbg, alu_op, pc_src, pc_en, zz[0]);
            end
            next_cycle();
            checks++;
            if (state_dbg !== 4'd0) begin
                failures++; $display("FAIL beq_return_z%0d: got %0d expected 0", zz, state_dbg);
            end
        end
    endtask

    task automatic test_fetch_stall;
        for (int c = 0; c < 4; c++) begin
            set_in(6'b000010, 1'b0, c == 3);
            checks++;
            if ({state_dbg, mem_req, ir_write, pc_en, bus_err} !==
                {4'd0, 1'b1, c == 3, c == 3, 1'b0}) begin
                failures++; $display("FAIL fetch_stall[%0d]: got st=%0d req=%b irw=%b pcen=%b berr=%b",
                                     c, state_dbg, mem_req, ir_write, pc_en, bus_err);
            end
            next_cycle();
        end
        set_in(6'b000010, 1'b0, 1'b0);
        checks++;
        if (state_dbg !== 4'd1) begin
            failures++; $display("FAIL fetch_stall_decode: got %0d expected 1", state_dbg);
        end
        next_cycle();
        next_cycle();
        set_in(6'b000010, 1'b0, 1'b0);
        checks++;
        if (state_dbg !== 4'd0) begin
            failures++; $display("FAIL jump_return: got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_timeout;
        set_in(6'b101011, 1'b0, 1'b1);
        next_cycle();
        next_cycle();
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            set_in(6'b101011, 1'b0, 1'b0);
            checks++;
            if ({state_dbg, mem_write, bus_err} !== {4'd5, 1'b1, c == 3}) begin
                failures++; $display("FAIL sw_timeout[%0d]: got st=%0d mw=%b berr=%b expected st=5 mw=1 berr=%b",
                                     c, state_dbg, mem_write, bus_err, c == 3);
            end
            next_cycle();
        end
        set_in(6'b101011, 1'b0, 1'b0);
        checks++;
        if ({state_dbg, mem_write, bus_err, reg_write} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL sw_after_timeout: got st=%0d mw=%b berr=%b rw=%b expected st=0 0 0 0",
                                 state_dbg, mem_write, bus_err, reg_write);
        end
    endtask

    task automatic test_illegal;
        set_in(6'b111111, 1'b0, 1'b1);
        next_cycle();
        set_in(6'b111111, 1'b0, 1'b1);
        checks++;
        if (obs !== model_out(1, 1'b1, 1'b0, 1'b0, 1'b1)) begin
            failures++; $display("FAIL illegal_decode: got %h expected %h", obs,
                                 model_out(1, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        next_cycle();
        set_in(6'b111111, 1'b0, 1'b0);
        checks++;
        if ({state_dbg, illegal_op, reg_write, pc_en, ir_write} !== {4'd0, 4'b0000}) begin
            failures++; $display("FAIL illegal_after: got st=%0d ill=%b rw=%b pcen=%b irw=%b expected st=0 0 0 0 0",
                                 state_dbg, illegal_op, reg_write, pc_en, ir_write);
        end
    endtask

    task automatic test_logic_imm;
        set_in(6'b001101, 1'b0, 1'b1);
        next_cycle();
        set_in(6'b001101, 1'b0, 1'b0);
`ifdef MIPS_CTRL_LOGIC_IMM_EN
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++; $display("FAIL ori_decode: got ill=%b expected 0", illegal_op);
        end
        next_cycle();
        set_in(6'b001101, 1'b0, 1'b0);
        checks++;
        if ({state_dbg, ext_op, alu_op} !== {4'd12, 1'b1, 2'b11}) begin
            failures++; $display("FAIL ori_logex: got st=%0d ext=%b aluop=%b expected st=12 1 11",
                                 state_dbg, ext_op, alu_op);
        end
        next_cycle();
        set_in(6'b001101, 1'b0, 1'b0);
        checks++;
        if ({state_dbg, reg_write} !== {4'd10, 1'b1}) begin
            failures++; $display("FAIL ori_immwb: got st=%0d rw=%b expected st=10 1", state_dbg, reg_write);
        end
`else
        checks++;
        if ({illegal_op, ext_op} !== 2'b10) begin
            failures++; $display("FAIL ori_illegal: got ill=%b ext=%b expected 1 0", illegal_op, ext_op);
        end
`endif
        next_cycle();
        set_in(6'b001101, 1'b0, 1'b0);
        checks++;
        if (state_dbg !== 4'd0) begin
            failures++; $display("FAIL ori_return: got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_async_reset;
        set_in(6'b100011, 1'b0, 1'b1);
        next_cycle();
        next_cycle();
        next_cycle();
        set_in(6'b100011, 1'b0, 1'b0);
        checks++;
        if ({state_dbg, mem_req} !== {4'd3, 1'b1}) begin
            failures++; $display("FAIL memread_req: got st=%0d req=%b expected st=3 1", state_dbg, mem_req);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({obs, state_dbg} !== {18'd0, 4'd0}) begin
            failures++; $display("FAIL async_reset: got ctrl=%h st=%0d expected 0 0", obs, state_dbg);
        end
        #2 rst_n = 1'b1;
        op = 6'b000010; mem_ready = 1'b1;
        #1;
        checks++;
        if ({state_dbg, mem_req} !== {4'd0, 1'b1}) begin
            failures++; $display("FAIL reset_release: got st=%0d req=%b expected st=0 1", state_dbg, mem_req);
        end
        next_cycle();
        checks++;
        if (state_dbg !== 4'd1) begin
            failures++; $display("FAIL resume_decode: got %0d expected 1", state_dbg);
        end
        next_cycle();
        next_cycle();
        set_in(6'b000010, 1'b0, 1'b0);
        checks++;
        if (state_dbg !== 4'd0) begin
            failures++; $display("FAIL resume_return: got %0d expected 0", state_dbg);
        end
    endtask

    // Random stream: each instruction is FETCH (with stalls/timeouts)
    // followed by its step list; memory steps may stall or time out.
    task automatic test_random;
        logic [5:0] ops[9];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b001100, 6'b001101, 6'b000000};
        for (int n = 0; n < 200; n++) begin
            logic [5:0] o;
            logic z, rdy, tmo, ill, aborted;
            int k, c, cyc, nsteps, guard, s;
            o = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            z = 1'($urandom);
            nsteps = steps_for(o, -1);
            ill = (nsteps == 1);
            cyc = 0;
            guard = 0;
            aborted = 1'b0;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 0;
            c = 0;
            forever begin
                rdy = (c >= k);
                tmo = (c == 3) && !rdy;
                set_in(o, z, rdy);
                checks++;
                if ({state_dbg, obs} !== {4'd0, model_out(0, rdy, z, tmo, 1'b0)}) begin
                    failures++; $display("FAIL rnd_fetch op=%b: got st=%0d ctrl=%h expected st=0 ctrl=%h",
                                         o, state_dbg, obs, model_out(0, rdy, z, tmo, 1'b0));
                end
                next_cycle();
                cyc++;
                guard++;
                if (rdy || guard > 40) break;
                if (tmo) begin k -= 4; c = 0; end
                else c++;
            end
            cyc = 1;
            for (int i = 0; i < nsteps && !aborted; i++) begin
                s = steps_for(o, i);
                if (s == 3 || s == 5) begin
                    k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
                    if (k != 0) cyc = -100;
                    for (c = 0; c < 8; c++) begin
                        rdy = (c >= k);
                        tmo = (c == 3) && !rdy;
                        set_in(o, z, rdy);
                        checks++;
                        if ({state_dbg, obs} !== {4'(s), model_out(s, rdy, z, tmo, 1'b0)}) begin
                            failures++; $display("FAIL rnd_mem op=%b c=%0d: got st=%0d ctrl=%h expected st=%0d ctrl=%h",
                                                 o, c, state_dbg, obs, s, model_out(s, rdy, z, tmo, 1'b0));
                        end
                        next_cycle();
                        cyc++;
                        if (tmo) aborted = 1'b1;
                        if (rdy || tmo) break;
                    end
                end else begin
                    rdy = 1'($urandom);
                    set_in(o, z, rdy);
                    checks++;
                    if ({state_dbg, obs} !== {4'(s), model_out(s, rdy, z, 1'b0, ill && s == 1)}) begin
                        failures++; $display("FAIL rnd_step op=%b: got st=%0d ctrl=%h expected st=%0d ctrl=%h",
                                             o, state_dbg, obs, s, model_out(s, rdy, z, 1'b0, ill && s == 1));
                    end
                    next_cycle();
                    cyc++;
                end
            end
            if (cyc > 0) begin
                checks++;
                if (cyc != nsteps + 1) begin
                    failures++; $display("FAIL rnd_latency op=%b: got %0d expected %0d", o, cyc, nsteps + 1);
                end
            end
        end
        set_in(6'b000000, 1'b0, 1'b0);
        checks++;
        if (state_dbg !== 4'd0) begin
            failures++; $display("FAIL rnd_end_state: got %0d expected 0", state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_lw_no_stall();
        test_branch();
        test_fetch_stall();
        test_timeout();
        test_illegal();
        test_logic_imm();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
